// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
//   Self-synchronising receive checker for the 1023-bit PRBS stream defined by
//   d[n] = d[n-7] ^ d[n-10]. It hunts for a non-zero 10-bit history, confirms
//   LOCK_CNT consecutive predictions, then flywheels on its own prediction.
//   While locked it counts checked bits and mismatches for BER measurement.
//   Lock is dropped when LOSS_THR errors fall inside one WIN-bit window.
//
// Ports
//   i_clk        bit clock, data sampled on the rising edge
//   i_rst        asynchronous reset, active low
//   i_data       serial PRBS bit under test
//   i_clr        synchronous clear of both counters (state/lock untouched)
//   o_lock       high while locked
//   o_err_pulse  one-cycle pulse per mismatch seen while locked
//   o_err_cnt    saturating error count (locked only)
//   o_bit_cnt    saturating checked-bit count (locked only)
// ---------------------------------------------------------------------------
module prbs_checker #(
    parameter int ERR_W    = 16,
    parameter int BIT_W    = 32,
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data,
    input  logic             i_clr,
    output logic             o_lock,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [BIT_W-1:0] o_bit_cnt
);

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_SYNC   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int WC_W = $clog2(WIN + 1);
    localparam int WE_W = $clog2(LOSS_THR + 1);

    localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_CNT);
    localparam logic [WC_W-1:0] WIN_V  = WC_W'(WIN);
    localparam logic [WE_W-1:0] THR_V  = WE_W'(LOSS_THR);
    localparam logic [3:0]      FILL_V = 4'd10;

    logic [1:0]       r_state;
    logic [9:0]       r_hist;
    logic [3:0]       r_fill;
    logic [MC_W-1:0]  r_match;
    logic [WC_W-1:0]  r_win;
    logic [WE_W-1:0]  r_win_err;
    logic             r_lock;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_cnt;
    logic [BIT_W-1:0] r_bit_cnt;

    logic             w_expected;
    logic             w_miss;
    logic             w_in_bit;
    logic [9:0]       w_hist_nxt;
    logic [3:0]       w_fill_nxt;
    logic [MC_W-1:0]  w_match_nxt;
    logic [WC_W-1:0]  w_win_nxt;
    logic [WE_W-1:0]  w_werr_nxt;

    assign w_expected  = r_hist[6] ^ r_hist[9];
    assign w_miss      = i_data ^ w_expected;
    // Once locked the history is fed from the prediction, so a single line
    // error is seen once instead of poisoning the next two predictions.
    assign w_in_bit    = (r_state == S_LOCKED) ? w_expected : i_data;
    assign w_hist_nxt  = {r_hist[8:0], w_in_bit};
    assign w_fill_nxt  = (r_fill == FILL_V) ? FILL_V : r_fill + 4'd1;
    assign w_match_nxt = r_match + 1'b1;
    assign w_win_nxt   = r_win + 1'b1;
    assign w_werr_nxt  = r_win_err + WE_W'(w_miss);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_HUNT;
            r_hist      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_win_err   <= '0;
            r_lock      <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_hist      <= w_hist_nxt;
            r_err_pulse <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    r_fill <= w_fill_nxt;
                    // Decide on the incoming history so the 10th bit already
                    // arms SYNC; an all-zero history never leaves HUNT.
                    if (w_fill_nxt == FILL_V && w_hist_nxt != '0) begin
                        r_state <= S_SYNC;
                        r_match <= '0;
                    end
                end
                S_SYNC: begin
                    if (w_miss) begin
                        r_state <= S_HUNT;
                        r_fill  <= '0;
                        r_match <= '0;
                    end else begin
                        r_match <= w_match_nxt;
                        if (w_match_nxt == LOCK_V) begin
                            r_state   <= S_LOCKED;
                            r_lock    <= 1'b1;
                            r_win     <= '0;
                            r_win_err <= '0;
                        end
                    end
                end
                S_LOCKED: begin
                    r_err_pulse <= w_miss;
                    if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_miss && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                    // Threshold is tested before the window wraps, so an
                    // error on the window's last bit still counts.
                    if (w_werr_nxt >= THR_V) begin
                        r_state   <= S_HUNT;
                        r_lock    <= 1'b0;
                        r_fill    <= '0;
                        r_win     <= '0;
                        r_win_err <= '0;
                    end else if (w_win_nxt == WIN_V) begin
                        r_win     <= '0;
                        r_win_err <= '0;
                    end else begin
                        r_win     <= w_win_nxt;
                        r_win_err <= w_werr_nxt;
                    end
                end
                default: begin
                    r_state <= S_HUNT;
                    r_fill  <= '0;
                    r_lock  <= 1'b0;
                end
            endcase
            if (i_clr) begin
                r_err_cnt <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

    assign o_lock      = r_lock;
    assign o_err_pulse = r_err_pulse;
    assign o_err_cnt   = r_err_cnt;
    assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Self-synchronising receive-side checker for the 1023-bit PRBS stream, recurrence d[n] = d[n-7] XOR d[n-10].
- Sits directly downstream of the PRBS generator, or after the CDR's recovered-data path.
- Acquires lock on the incoming serial bit, then flywheels on its own prediction.
- Counts bit errors and checked bits for BER measurement, and drops lock on excessive errors.

Parameters:
- ERR_W, 16, width of saturating error counter
- BIT_W, 32, width of saturating checked-bit counter
- LOCK_CNT, 16, consecutive matching bits in SYNC required to declare lock (>=1)
- WIN, 64, loss-of-lock observation window in bits (>=2)
- LOSS_THR, 8, errors within one window that force loss of lock (1..WIN)

Ports:
- clk  in  1  bit clock; data sampled on rising edge (generator updates on falling edge, giving half-cycle margin)
- rst  in  1  asynchronous, active-low reset
- data  in  1  serial PRBS bit under test
- clr  in  1  synchronous clear of err_cnt and bit_cnt; state and lock unaffected
- lock  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse for each mismatch counted in LOCKED
- err_cnt  out  ERR_W  saturating count of errors in LOCKED
- bit_cnt  out  BIT_W  saturating count of bits checked in LOCKED

Behaviour:
- Reset (rst=0, async):
  - state=HUNT; hist[9:0]=0; fill_cnt=0; match_cnt=0; win_cnt=0; win_err=0.
  - lock=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- History register:
  - Every rising edge shifts left: hist[0] <= in_bit, where hist[0] is the most recent bit.
  - expected = hist[6] XOR hist[9].
  - in_bit = data in HUNT and SYNC; in_bit = expected in LOCKED (flywheel, so a single line error is counted once, not tripled).
- HUNT:
  - fill_cnt increments per bit, saturating at 10.
  - Leave when fill_cnt==10 and hist != 0: go to SYNC with match_cnt=0.
  - An all-zero history stays in HUNT, so a stuck-at-0 line never locks.
- SYNC:
  - Compare data vs expected each cycle.
  - Match: match_cnt++. On reaching LOCK_CNT go to LOCKED; lock=1 registered on that same edge; win_cnt=0, win_err=0.
  - Mismatch: go to HUNT with fill_cnt=0, match_cnt=0. hist keeps shifting data.
- LOCKED, per cycle:
  - bit_cnt++ (saturating).
  - On mismatch: err_pulse=1, err_cnt++ (saturating at all-ones), win_err++.
  - win_cnt++.
  - If win_err (including this cycle's error) reaches LOSS_THR: go to HUNT, lock=0, fill_cnt=0. err_cnt/bit_cnt are retained.
  - Else if win_cnt reaches WIN: win_cnt=0, win_err=0. The error on the window's last bit counts toward the threshold before clearing.
- clr:
  - Zeroes err_cnt and bit_cnt. If coincident with an error or checked bit, clr wins (result 0).
  - err_pulse still fires.
- Outputs are registered; err_pulse is low in HUNT/SYNC.
- Reset mid-LOCKED: immediate return to reset values and a full reacquire.

Test Plan:
- Generator model seeded 0b0001110001 (first bits 0,0,0,1,1,1,0,0,0,1) driving data from reset release.
  - Required: lock rises after the 26th sampled bit (10 HUNT + 16 SYNC).
  - Then err_cnt=0 and bit_cnt increments by 1 per cycle for 2046 cycles.
- While locked, invert one bit.
  - Required: exactly one err_pulse, err_cnt=1, lock stays 1, following bits match again (flywheel, no error tripling).
- While locked, invert 8 bits within one 64-bit window.
  - Required: lock drops on the edge sampling the 8th error, err_cnt=8.
  - Reacquisition follows 26 clean bits later.
- Invert 7 bits in window A and 7 bits in the next window B, including one error on A's last bit.
  - Required: lock held throughout, err_cnt=14.
- data stuck at 0 for 500 cycles, then stuck at 1.
  - Required: lock never asserts on all-zero input.
  - On all-ones: SYNC is entered, the first compare mismatches, HUNT repeats, lock stays 0.
- Force err_cnt to saturate (ERR_W=4 build, 20 errors), then pulse clr coincident with an error.
  - Required: err_cnt holds 15, then reads 0 after clr; bit_cnt reads 0.
  - Async rst mid-LOCKED: all outputs 0 immediately.
